// File: rtl/uart_transmitter.sv
// UART transmitter: byte FIFO feeding a frame serialiser (start, 8 data LSB first,
// optional parity, stop, optional idle gap). One bit lasts OVERSAMPLE clocks.
module uart_transmitter #(
  parameter int OVERSAMPLE = 5,
  parameter int PARITY     = 1,
  parameter int GAP_BITS   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA,
  input  logic       WR,
  output logic       READY,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int GAP_CYC = (GAP_BITS > 0) ? GAP_BITS * OVERSAMPLE : OVERSAMPLE;
  localparam int TMAX    = (GAP_CYC > OVERSAMPLE) ? GAP_CYC : OVERSAMPLE;
  localparam int TW      = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  // Parity bit for the configured mode; none returns the idle level.
  function automatic logic parity_bit(input logic [7:0] b);
    if (PARITY == 1)      return ~^b;
    else if (PARITY == 2) return ^b;
    else                  return 1'b1;
  endfunction

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          push, pop;

  state_t        state_q, state_n;
  logic [TW-1:0] tick_q, tick_n, tick_lim;
  logic [2:0]    idx_q, idx_n;
  logic          tx_q, tx_n;
  logic [7:0]    shift_q;
  logic          load, tick_last;

  assign READY = (count_q != (AW+1)'(FIFO_DEPTH));
  assign push  = WR && READY;
  assign pop   = load;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr_q] <= DATA;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign tick_lim  = (state_q == S_GAP) ? TW'(GAP_CYC - 1) : TW'(OVERSAMPLE - 1);
  assign tick_last = (tick_q == tick_lim);

  // Next-state logic: every TX change is decided here and lands on a bit boundary.
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    idx_n   = idx_q;
    tx_n    = tx_q;
    load    = 1'b0;
    if (state_q != S_IDLE) tick_n = tick_last ? '0 : tick_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          load    = 1'b1;
          tx_n    = 1'b0;
          tick_n  = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick_last) begin
          state_n = S_DATA;
          idx_n   = 3'd0;
          tx_n    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick_last) begin
          if (idx_q == 3'd7) begin
            if (PARITY != 0) begin
              state_n = S_PARITY;
              tx_n    = parity_bit(shift_q);
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx_q + 3'd1;
            tx_n  = shift_q[idx_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (tick_last) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick_last) begin
          state_n = (GAP_BITS > 0) ? S_GAP : S_IDLE;
          tx_n    = 1'b1;
        end
      end
      S_GAP: begin
        if (tick_last) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        tick_n  = '0;
      end
    endcase
  end

  // FSM control registers; reset truncates any frame and forces the line idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      idx_q   <= idx_n;
      tx_q    <= tx_n;
    end
  end

  // Byte under transmission, captured on the pop and held for the whole frame.
  always_ff @(posedge CLK) begin
    if (load) shift_q <= mem[rptr_q];
  end

  assign TX   = tx_q;
  assign BUSY = (state_q != S_IDLE) || (count_q != '0);
  assign DONE = (state_q == S_STOP) && tick_last;

endmodule
